// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - K&S instruction set shared by decoder, control unit and bench
package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control unit <-> datapath bundle
// master: control unit (drives strobes, reads instruction and flags)
// slave : datapath side (reads strobes, drives instruction and flags)
interface control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic       zero_op;
  logic       neg_op;
  logic       unsigned_overflow;
  logic       signed_overflow;
  logic       branch;
  logic       pc_enable;
  logic       ir_enable;
  logic       addr_sel;
  logic       c_sel;
  logic [1:0] operation;
  logic       write_reg_enable;
  logic       flags_reg_enable;
  logic       ram_write_enable;
  logic       halt;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle Moore controller for the K&S datapath
// Ports: clk, rst_n (sync active-low), bus (control_unit_if.master):
//   inputs decoded_instruction and flag-register outputs, outputs every
//   datapath strobe, RAM write enable and halt.
// Build option: K_AND_S_SIGNED_OV_EN selects signed_overflow for I_BOV/I_BNOV,
//   otherwise unsigned_overflow is used.
module control_unit
  import k_and_s_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LOAD_ADDR, S_LOAD_WB, S_STORE,
    S_MOVE, S_ALU, S_BRANCH, S_HALT
  } state_t;

  state_t state_q, state_d;
  // Set for the cycles in which reset was sampled low; masks every output so
  // the FETCH state loaded by reset stays silent until reset is sampled high.
  logic   reset_hold_q, reset_hold_d;
  logic   ov_flag;

`ifdef K_AND_S_SIGNED_OV_EN
  logic unused_ov;
  assign ov_flag   = bus.signed_overflow;
  assign unused_ov = bus.unsigned_overflow;
`else
  logic unused_ov;
  assign ov_flag   = bus.unsigned_overflow;
  assign unused_ov = bus.signed_overflow;
`endif

  // Next state: flags are consumed only here, never by the outputs.
  always_comb begin
    state_d      = state_q;
    reset_hold_d = 1'b0;
    if (reset_hold_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:     state_d = S_DECODE;
        S_DECODE: begin
          case (bus.decoded_instruction)
            I_LOAD:                     state_d = S_LOAD_ADDR;
            I_STORE:                    state_d = S_STORE;
            I_MOVE:                     state_d = S_MOVE;
            I_ADD, I_SUB, I_AND, I_OR:  state_d = S_ALU;
            I_HALT:                     state_d = S_HALT;
            I_BRANCH:                   state_d = S_BRANCH;
            I_BZERO:  state_d = bus.zero_op  ? S_BRANCH : S_FETCH;
            I_BNZERO: state_d = !bus.zero_op ? S_BRANCH : S_FETCH;
            I_BNEG:   state_d = bus.neg_op   ? S_BRANCH : S_FETCH;
            I_BNNEG:  state_d = !bus.neg_op  ? S_BRANCH : S_FETCH;
            I_BOV:    state_d = ov_flag      ? S_BRANCH : S_FETCH;
            I_BNOV:   state_d = !ov_flag     ? S_BRANCH : S_FETCH;
            default:                    state_d = S_FETCH;
          endcase
        end
        S_LOAD_ADDR: state_d = S_LOAD_WB;
        S_HALT:      state_d = S_HALT;
        default:     state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      reset_hold_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      reset_hold_q <= reset_hold_d;
    end
  end

  // Moore outputs from the state register (and the stable IR in ALU only).
  always_comb begin
    bus.branch           = 1'b0;
    bus.pc_enable        = 1'b0;
    bus.ir_enable        = 1'b0;
    bus.addr_sel         = 1'b0;
    bus.c_sel            = 1'b0;
    bus.operation        = 2'b00;
    bus.write_reg_enable = 1'b0;
    bus.flags_reg_enable = 1'b0;
    bus.ram_write_enable = 1'b0;
    bus.halt             = 1'b0;
    if (!reset_hold_q) begin
      case (state_q)
        S_FETCH:     bus.ir_enable = 1'b1;
        S_DECODE:    bus.pc_enable = 1'b1;
        S_LOAD_ADDR: bus.addr_sel  = 1'b1;
        S_LOAD_WB: begin
          bus.addr_sel         = 1'b1;
          bus.c_sel            = 1'b1;
          bus.write_reg_enable = 1'b1;
        end
        S_STORE: begin
          bus.addr_sel         = 1'b1;
          bus.ram_write_enable = 1'b1;
        end
        S_MOVE: begin
          // OR of the source with itself passes it through unchanged.
          bus.operation        = 2'b10;
          bus.write_reg_enable = 1'b1;
        end
        S_ALU: begin
          bus.write_reg_enable = 1'b1;
          bus.flags_reg_enable = 1'b1;
          case (bus.decoded_instruction)
            I_AND:   bus.operation = 2'b01;
            I_OR:    bus.operation = 2'b10;
            I_SUB:   bus.operation = 2'b11;
            default: bus.operation = 2'b00;
          endcase
        end
        S_BRANCH: begin
          bus.pc_enable = 1'b1;
          bus.branch    = 1'b1;
        end
        S_HALT:      bus.halt = 1'b1;
        default:     bus.halt = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle Moore controller that sequences the K&S `data_path` through fetch, decode and execute. It consumes the decoded instruction and the registered flags from the datapath. It drives every datapath control strobe, plus the RAM write enable and a halt indication, to the processor top level. One instruction is in flight at a time; there is no pipelining.

## Interface
Parameters:
- none; the instruction set comes from `k_and_s_pkg::decoded_instruction_type`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `decoded_instruction` input `decoded_instruction_type`: decoder output of the current IR.
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow` input 1 each: flag-register outputs.
- `branch` output 1: PC loads the instruction address field instead of PC+1.
- `pc_enable` output 1: PC update strobe.
- `ir_enable` output 1: IR load strobe (`data_in` into IR).
- `addr_sel` output 1: 0 = `ram_addr` from PC; 1 = `ram_addr` from the instruction address field.
- `c_sel` output 1: 0 = `bus_c` from ALU; 1 = `bus_c` from `data_in`.
- `operation` output 2: ALU op; 00 add, 01 and, 10 or, 11 sub.
- `write_reg_enable` output 1: register-file write of `bus_c`.
- `flags_reg_enable` output 1: flag register captures the ALU flags.
- `ram_write_enable` output 1: RAM writes `data_out` at `ram_addr`.
- `halt` output 1: processor stopped.

## Operation
States: FETCH, DECODE, LOAD_ADDR, LOAD_WB, STORE, MOVE, ALU, BRANCH, HALT. Outputs not listed for a state are 0.
- **FETCH**
  - Outputs: `addr_sel`=0, `ir_enable`=1.
  - Next: DECODE.
- **DECODE**
  - Outputs: `pc_enable`=1, `branch`=0, so PC becomes PC+1 for every instruction.
  - Next, by `decoded_instruction`:
    - I_LOAD goes to LOAD_ADDR.
    - I_STORE goes to STORE.
    - I_MOVE goes to MOVE.
    - I_ADD, I_SUB, I_AND and I_OR go to ALU.
    - I_HALT goes to HALT.
    - I_NOP, or any unlisted encoding, goes to FETCH.
  - Branch decisions are made here from the flag inputs sampled this cycle. A taken branch goes to BRANCH; an untaken branch goes to FETCH.
    - I_BRANCH: always taken.
    - I_BZERO: taken if `zero_op`; I_BNZERO: taken if not `zero_op`.
    - I_BNEG: taken if `neg_op`; I_BNNEG: taken if not `neg_op`.
    - I_BOV: taken if the selected overflow flag is 1; I_BNOV: taken if it is 0 (selection in Configuration).
- **LOAD_ADDR**
  - Outputs: `addr_sel`=1. This cycle presents the address to RAM.
  - Next: LOAD_WB.
- **LOAD_WB**
  - Outputs: `addr_sel`=1, `c_sel`=1, `write_reg_enable`=1.
  - Next: FETCH.
- **STORE**
  - Outputs: `addr_sel`=1, `ram_write_enable`=1.
  - Next: FETCH.
- **MOVE**
  - Outputs: `operation`=10 (OR with a=b passes the source through), `c_sel`=0, `write_reg_enable`=1, `flags_reg_enable`=0.
  - Next: FETCH.
- **ALU**
  - Outputs: `c_sel`=0, `write_reg_enable`=1, `flags_reg_enable`=1.
  - `operation`: I_ADD 00, I_AND 01, I_OR 10, I_SUB 11.
  - Next: FETCH.
- **BRANCH**
  - Outputs: `pc_enable`=1, `branch`=1.
  - Next: FETCH.
- **HALT**
  - Outputs: `halt`=1, all other strobes 0.
  - Next: HALT, until reset.

Additional rules:
- `operation` is 00 in every state except MOVE and ALU.
- `decoded_instruction` is stable from DECODE until the next FETCH, because the IR is written only in FETCH. Outputs in FETCH must not depend on it.
- At most one of `ir_enable`, `write_reg_enable`, `ram_write_enable` and `pc_enable` is high in any cycle.

## Timing
- Reset:
  - `rst_n`=0 at a rising edge puts the state in FETCH on the next cycle.
  - While reset is held, every output is 0, including `halt`.
  - The first FETCH strobe appears in the first cycle after `rst_n` is sampled high.
  - Reset takes priority in every state, including mid-LOAD and HALT. A write strobe from an aborted state must not appear after reset.
- Cycles per instruction:
  - NOP, untaken branch: 2.
  - STORE, MOVE, ALU, taken branch: 3.
  - LOAD: 4.
- The flag register updates at the end of an ALU state, so a branch immediately following an ALU instruction sees the new flags in its DECODE.
- All outputs are combinational from the state register and `decoded_instruction` only. Flag inputs affect only next-state logic, so no output has a combinational path from a flag input.

## Configuration
- `K_AND_S_SIGNED_OV_EN` defined: I_BOV and I_BNOV test `signed_overflow`.
- `K_AND_S_SIGNED_OV_EN` undefined: I_BOV and I_BNOV test `unsigned_overflow`.
- No other behaviour changes; the other overflow input is unused in that build.

## Test plan
- Hold `rst_n`=0 for 3 cycles, then release → every output is 0 during reset; the first post-reset cycle has `ir_enable`=1, `addr_sel`=0; the next has `pc_enable`=1, `branch`=0.
- I_ADD, then I_SUB → the ALU cycle shows `operation`=00, `write_reg_enable`=1, `flags_reg_enable`=1, and the sequence is 3 cycles per instruction; I_SUB's ALU cycle shows `operation`=11.
- I_LOAD → sequence FETCH, DECODE, LOAD_ADDR (`addr_sel`=1 only), LOAD_WB (`addr_sel`=1, `c_sel`=1, `write_reg_enable`=1), then FETCH.
- I_BZERO with `zero_op`=1 → BRANCH cycle with `pc_enable`=1, `branch`=1. Same with `zero_op`=0 → returns to FETCH after 2 cycles with no `branch` pulse.
- I_BOV with `signed_overflow`=1, `unsigned_overflow`=0 → taken when built with `K_AND_S_SIGNED_OV_EN`, untaken without it.
- I_HALT → `halt`=1 for 20 cycles with all strobes 0; assert `rst_n`=0 during an I_LOAD's LOAD_ADDR → next cycle FETCH state, no `write_reg_enable` pulse observed.
